// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive, response and status signals of the ALU issue controller.
// The environment side uses the master modport; the controller uses the slave modport.
interface alu_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_aluop;
    logic [5:0]       req_funct;
    logic [31:0]      req_a;
    logic [31:0]      req_b;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_op;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_overflow;

    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_result;
    logic             resp_zero;
    logic             resp_overflow;
    logic             resp_err;

    logic [CNT_W-1:0] ops_done;
    logic             ovf_sticky;
    logic             ovf_clr;

    modport master (
        output req_valid, req_aluop, req_funct, req_a, req_b,
        output alu_result, alu_zero, alu_overflow,
        output resp_ready, ovf_clr,
        input  req_ready, alu_a, alu_b, alu_op,
        input  resp_valid, resp_result, resp_zero, resp_overflow, resp_err,
        input  ops_done, ovf_sticky
    );

    modport slave (
        input  req_valid, req_aluop, req_funct, req_a, req_b,
        input  alu_result, alu_zero, alu_overflow,
        input  resp_ready, ovf_clr,
        output req_ready, alu_a, alu_b, alu_op,
        output resp_valid, resp_result, resp_zero, resp_overflow, resp_err,
        output ops_done, ovf_sticky
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit ripple ALU: decodes ALUOp/funct, holds operands for
// EXEC_CYCLES, captures the ALU outputs and returns them over a valid/ready response.
module alu_issue_ctrl #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input logic           clk_in,
    input logic           reset_in,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] LAST_EXEC = 4'(EXEC_CYCLES - 1);
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0110;

    state_t     state;
    logic [3:0] exec_cnt;
    logic [3:0] dec_op;
    logic       dec_legal;
    logic       masked_ovf;

    always_comb begin
        dec_op    = OP_ADD;
        dec_legal = 1'b1;
        case (bus.req_aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (bus.req_funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = 4'b0000;
                    6'b100101: dec_op = 4'b0001;
                    6'b100111: dec_op = 4'b1100;
                    6'b101010: dec_op = 4'b0111;
                    default:   dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Overflow only has meaning for the arithmetic ops; logic and slt results ignore it.
    assign masked_ovf = bus.alu_overflow & ((bus.alu_op == OP_ADD) | (bus.alu_op == OP_SUB));

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state             <= IDLE;
            exec_cnt          <= '0;
            bus.req_ready     <= 1'b1;
            bus.alu_a         <= '0;
            bus.alu_b         <= '0;
            bus.alu_op        <= '0;
            bus.resp_valid    <= 1'b0;
            bus.resp_result   <= '0;
            bus.resp_zero     <= 1'b0;
            bus.resp_overflow <= 1'b0;
            bus.resp_err      <= 1'b0;
            bus.ops_done      <= '0;
            bus.ovf_sticky    <= 1'b0;
        end else begin
            // A clear is overridden below by a same-cycle overflowing capture.
            if (bus.ovf_clr) begin
                bus.ovf_sticky <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        if (dec_legal) begin
                            bus.alu_a  <= bus.req_a;
                            bus.alu_b  <= bus.req_b;
                            bus.alu_op <= dec_op;
                            exec_cnt   <= '0;
                            state      <= EXEC;
                        end else begin
                            bus.resp_valid    <= 1'b1;
                            bus.resp_err      <= 1'b1;
                            bus.resp_result   <= '0;
                            bus.resp_zero     <= 1'b0;
                            bus.resp_overflow <= 1'b0;
                            state             <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (exec_cnt == LAST_EXEC) begin
                        bus.resp_valid    <= 1'b1;
                        bus.resp_err      <= 1'b0;
                        bus.resp_result   <= bus.alu_result;
                        bus.resp_zero     <= bus.alu_zero;
                        bus.resp_overflow <= masked_ovf;
                        bus.ops_done      <= bus.ops_done + CNT_W'(1);
                        if (masked_ovf) begin
                            bus.ovf_sticky <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        exec_cnt <= exec_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
